// File: rtl/mem_line_responder.sv
// Fixed-latency line memory responder: one outstanding read or write of a 128-bit line,
// a one-cycle mem_ready pulse LATENCY cycles after acceptance, then a one-cycle guard gap.
module mem_line_responder #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned LINE_AW = 8,
   localparam int unsigned ADDR_W = 28,
   localparam int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              proto_err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned LINES = 2 ** LINE_AW;
   localparam bit          DIRECT_RESP = (LATENCY <= 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_wr_q;
   logic [LINE_AW-1:0]   addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic                 ready_d;
   logic                 perr_d;
   logic                 accept_c;
   logic                 rd_load_c;
   logic                 wr_en_c;
   logic [LINE_AW-1:0]   rd_idx_c;
   logic [ADDR_W-1:0]    addr_unused_c;

   logic [DATA_W-1:0]    store [LINES];

   // Upper address bits alias onto the same lines and are intentionally ignored.
   assign addr_unused_c = mem_addr;

   // With LATENCY=1 the read happens on the accepting edge, before addr_q is valid.
   assign rd_idx_c = accept_c ? mem_addr[LINE_AW-1:0] : addr_q;

   // Next-state, counter and strobe decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      perr_d    = proto_err;
      accept_c  = 1'b0;
      rd_load_c = 1'b0;
      wr_en_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               accept_c = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               if (mem_read && mem_write) begin
                  perr_d = 1'b1;
               end
               if (DIRECT_RESP) begin
                  state_d   = RESP;
                  ready_d   = 1'b1;
                  rd_load_c = !mem_write;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d   = RESP;
               ready_d   = 1'b1;
               rd_load_c = !is_wr_q;
            end
         end
         RESP: begin
            state_d = GAP;
            wr_en_c = is_wr_q;
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture; a write wins when both request lines are high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept_c) begin
         is_wr_q <= mem_write;
         addr_q  <= mem_addr[LINE_AW-1:0];
         wdata_q <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         proto_err <= 1'b0;
      end else begin
         mem_ready <= ready_d;
         proto_err <= perr_d;
         if (rd_load_c) begin
            mem_rdata <= store[rd_idx_c];
         end
      end
   end

   // Line storage is never reset; a reset mid-request leaves state outside RESP so no write lands.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         store[addr_q] <= wdata_q;
      end
   end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the number of cycles from request acceptance to mem_ready (legal range 1..15).
REQ-002 The block SHALL have parameter LINE_AW, default 8, meaning the line-address bits used to index storage (2^LINE_AW lines of 128 bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_read, input, 1 bit: line read request, level, held by the requester until mem_ready.
REQ-006 The block SHALL have port mem_write, input, 1 bit: line write request, level, held by the requester until mem_ready.
REQ-007 The block SHALL have port mem_addr, input, 28 bits: line address; only bits [LINE_AW-1:0] index storage, and the upper bits alias.
REQ-008 The block SHALL have port mem_wdata, input, 128 bits: write line data.
REQ-009 The block SHALL have port mem_rdata, output, 128 bits: registered read line data.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse for the current request.
REQ-011 The block SHALL have port proto_err, output, 1 bit: sticky flag, set when mem_read and mem_write are both sampled high in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, RESP and GAP, encoded in 2 bits.
REQ-013 In IDLE, with mem_read or mem_write high at a clock edge, the block SHALL latch the operation, mem_addr[LINE_AW-1:0] and mem_wdata, load the counter with LATENCY-1, and go to BUSY (LATENCY>1) or RESP (LATENCY=1).
REQ-014 In BUSY, the block SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1; input changes during BUSY SHALL be ignored.
REQ-015 The block SHALL assert mem_ready only in RESP, for exactly one cycle, so that a request first sampled at edge E0 sees mem_ready high in the cycle following edge E0+LATENCY-1.
REQ-016 For reads, mem_rdata SHALL be loaded from storage[latched addr] at the edge entering RESP, and SHALL hold that value through RESP and until the next read enters RESP.
REQ-017 For writes, storage[latched addr] SHALL be written with the latched wdata at the edge leaving RESP; mem_rdata SHALL be unchanged by writes.
REQ-018 RESP SHALL always go to GAP, and GAP SHALL always go to IDLE; requests seen in RESP or GAP SHALL be ignored, which absorbs requesters that deassert one cycle late.
REQ-019 When read and write are both high in IDLE, the block SHALL treat the request as a write and set proto_err, which stays set until reset.
REQ-020 A read to an address written by an earlier, completed request SHALL return the written data; back-to-back write-then-read to the same line SHALL return the new data.
REQ-021 Storage contents SHALL NOT be reset; the value of a line that has never been written is undefined.

Reset
REQ-022 On rst_n low, independent of clk, the block SHALL set state=IDLE, counter=0, mem_ready=0, mem_rdata=0 and proto_err=0.
REQ-023 A reset asserted in BUSY or RESP SHALL abort the request; a pending write SHALL NOT update storage.
REQ-024 After rst_n rises, the first edge with a request high SHALL be accepted as in REQ-013.

Verification
REQ-025 Scenario 1: LATENCY=4, write addr 0x05 data 0x1111_2222_3333_4444_5555_6666_7777_8888, held until ready -> mem_ready high for exactly 1 cycle, in the 4th cycle after the accepting edge; then read 0x05 -> mem_rdata equals that data in the ready cycle.
REQ-026 Scenario 2: read 0x105 after the Scenario 1 write (LINE_AW=8, aliasing) -> returns the 0x05 data.
REQ-027 Scenario 3: requester keeps mem_read high for 1 cycle after ready -> no second mem_ready; the next request is accepted only after GAP, so the earliest next ready is LATENCY+2 cycles after the previous ready.
REQ-028 Scenario 4: mem_read=mem_write=1 in IDLE, addr 0x07, wdata 0xA5..A5 -> proto_err=1 sticky; a later read of 0x07 returns 0xA5..A5.
REQ-029 Scenario 5: write 0x09 new data, pull rst_n low mid-BUSY -> mem_ready/mem_rdata/proto_err become 0 immediately; a read of 0x09 after reset returns the prior contents, not the aborted data.
REQ-030 Scenario 6: LATENCY=1 -> mem_ready in the cycle right after the accepting edge; the mem_addr/mem_wdata change during BUSY test runs with LATENCY=4 and yields the values latched at acceptance.
